bcd_scan_display: RTL and testbench

- Downstream consumer of the 16-bit packed-BCD word produced by the binary-to-BCD converter.
- Time-multiplexes four BCD digits onto a common-anode 4-digit 7-segment display. All segment and anode lines are active-low.
- A load/shadow register makes digit updates frame-atomic, so the display never tears.
- Supports optional leading-zero blanking and per-digit decimal points.

---
 rtl/bcd_scan_display.sv | 163 ++++++++++++++++
 tb/tb_bcd_scan_display.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_display.sv
// Four-digit common-anode 7-segment scanner for a packed-BCD word.
// A pending/display register pair makes value changes take effect only at frame starts.
module bcd_scan_display #(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] bcd_in,
  input  logic        bcd_load,
  input  logic        blank_lz,
  input  logic [3:0]  dp_en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int              DW       = $clog2(SCAN_DIV);
  localparam logic [DW-1:0]   DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0]   DIV_ONE  = DW'(1);

  typedef enum logic [2:0] {S_IDLE, S_D0, S_D1, S_D2, S_D3} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [DW-1:0] r_div;
  logic          w_tick;
  logic [15:0]   r_pending;
  logic [15:0]   r_disp;
  logic [15:0]   w_disp_nxt;
  logic [1:0]    w_digit;
  logic [3:0]    w_nib;
  logic          w_blank;
  logic          w_frame_nxt;
  logic [3:0]    w_an_nxt;
  logic [6:0]    w_seg_nxt;
  logic          w_dp_nxt;

  // Segment pattern {g,f,e,d,c,b,a}, active-low; non-decimal nibbles render as a dash
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b0111111;
    endcase
  endfunction

  // True when digit d and every digit to its left are zero; digit 0 always shows
  function automatic logic lz_blank(input logic [15:0] val, input logic [1:0] d);
    case (d)
      2'd3:    lz_blank = (val[15:12] == 4'd0);
      2'd2:    lz_blank = (val[15:8]  == 8'd0);
      2'd1:    lz_blank = (val[15:4]  == 12'd0);
      default: lz_blank = 1'b0;
    endcase
  endfunction

  // Free-running scan divider
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
    end else if (r_div == DIV_LAST) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_ONE;
    end
  end

  assign w_tick = (r_div == DIV_LAST);

  // Pending register: last load before a frame boundary wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= 16'h0000;
    end else if (bcd_load) begin
      r_pending <= bcd_in;
    end
  end

  // Scan state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and next output values, precomputed so outputs can be registered
  always_comb begin
    w_state_nxt = r_state;
    w_digit     = 2'd0;
    w_nib       = 4'd0;
    w_an_nxt    = 4'b1111;
    w_seg_nxt   = 7'b1111111;
    w_dp_nxt    = 1'b1;
    if (w_tick) begin
      case (r_state)
        S_IDLE:  w_state_nxt = S_D0;
        S_D0:    w_state_nxt = S_D1;
        S_D1:    w_state_nxt = S_D2;
        S_D2:    w_state_nxt = S_D3;
        S_D3:    w_state_nxt = S_D0;
        default: w_state_nxt = S_IDLE;
      endcase
    end else begin
      w_state_nxt = r_state;
    end
    w_frame_nxt = w_tick && (w_state_nxt == S_D0);
    // The D0 digit must already see the value being transferred on this edge
    w_disp_nxt  = w_frame_nxt ? r_pending : r_disp;
    case (w_state_nxt)
      S_D1:    w_digit = 2'd1;
      S_D2:    w_digit = 2'd2;
      S_D3:    w_digit = 2'd3;
      default: w_digit = 2'd0;
    endcase
    case (w_digit)
      2'd1:    w_nib = w_disp_nxt[7:4];
      2'd2:    w_nib = w_disp_nxt[11:8];
      2'd3:    w_nib = w_disp_nxt[15:12];
      default: w_nib = w_disp_nxt[3:0];
    endcase
    w_blank = blank_lz && lz_blank(w_disp_nxt, w_digit);
    if (w_state_nxt != S_IDLE) begin
      w_an_nxt  = ~(4'b0001 << w_digit);
      w_seg_nxt = w_blank ? 7'b1111111 : seg_decode(w_nib);
      w_dp_nxt  = ~dp_en[w_digit];
    end else begin
      w_an_nxt  = 4'b1111;
      w_seg_nxt = 7'b1111111;
      w_dp_nxt  = 1'b1;
    end
  end

  // Display register and output registers, updated on tick edges only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_disp     <= 16'h0000;
      an         <= 4'b1111;
      seg        <= 7'b1111111;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= w_frame_nxt;
      if (w_tick) begin
        r_disp <= w_disp_nxt;
        an     <= w_an_nxt;
        seg    <= w_seg_nxt;
        dp     <= w_dp_nxt;
      end
    end
  end

endmodule

// File: tb/tb_bcd_scan_display.sv
// Self-checking bench for bcd_scan_display with SCAN_DIV=4; a frame model pushes
// expected per-digit outputs to a queue that is popped as each digit slot is observed.
module tb_bcd_scan_display;

  localparam int SCAN_DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] bcd_in = 16'h0000;
  logic        bcd_load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [3:0]  dp_en = 4'b0000;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  bcd_scan_display #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bcd_in     (bcd_in),
    .bcd_load   (bcd_load),
    .blank_lz   (blank_lz),
    .dp_en      (dp_en),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    logic       e_fd;
  } exp_t;

  exp_t        sb_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] m_pend = 16'h0000;
  logic [15:0] m_disp = 16'h0000;
  logic        cur_blz = 1'b0;
  logic [3:0]  cur_dp = 4'b0000;

  function automatic logic [6:0] ref_seg(input logic [3:0] n);
    case (n)
      4'd0:    ref_seg = 7'b1000000;
      4'd1:    ref_seg = 7'b1111001;
      4'd2:    ref_seg = 7'b0100100;
      4'd3:    ref_seg = 7'b0110000;
      4'd4:    ref_seg = 7'b0011001;
      4'd5:    ref_seg = 7'b0010010;
      4'd6:    ref_seg = 7'b0000010;
      4'd7:    ref_seg = 7'b1111000;
      4'd8:    ref_seg = 7'b0000000;
      4'd9:    ref_seg = 7'b0010000;
      default: ref_seg = 7'b0111111;
    endcase
  endfunction

  task automatic push_frame(input logic [15:0] v, input logic blz, input logic [3:0] dpn);
    for (int n = 0; n < 4; n++) begin
      exp_t        e;
      logic [15:0] up;
      up      = v >> (4 * n);
      e.e_an  = 4'b1111;
      e.e_an[n] = 1'b0;
      e.e_seg = (blz && n != 0 && up == 16'h0000) ? 7'b1111111 : ref_seg(up[3:0]);
      e.e_dp  = ~dpn[n];
      e.e_fd  = (n == 0);
      sb_q.push_back(e);
    end
  endtask

  task automatic check_idle(input string tag);
    for (int c = 0; c < SCAN_DIV; c++) begin
      vectors++;
      if ({an, seg, dp, frame_done} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
        miscompares++;
        $display("FAIL %s idle cycle %0d: an=%b seg=%b dp=%b fd=%b, required an=1111 seg=1111111 dp=1 fd=0",
                 tag, c, an, seg, dp, frame_done);
      end
      @(negedge clk);
    end
  endtask

  // Observes one whole frame; optionally pulses bcd_load at (slot ls, cycle lc) and
  // applies new blank_lz/dp_en on the last cycle so they take effect at the next frame.
  task automatic run_frame(input int ls, input int lc, input logic [15:0] lv,
                           input logic nb, input logic [3:0] nd, input string tag);
    exp_t        e;
    logic [12:0] exp_v;
    int          wait_n;
    push_frame(m_disp, cur_blz, cur_dp);
    wait_n = 0;
    while (frame_done !== 1'b1 && wait_n < 40) begin
      @(negedge clk);
      wait_n++;
    end
    vectors++;
    if (frame_done !== 1'b1) begin
      miscompares++;
      $display("FAIL %s frame_start: frame_done=%b after %0d cycles, required 1", tag, frame_done, wait_n);
    end
    for (int d = 0; d < 4; d++) begin
      e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
      for (int c = 0; c < SCAN_DIV; c++) begin
        bcd_load = 1'b0;
        if (d == ls && c == lc) begin
          bcd_load = 1'b1;
          bcd_in   = lv;
        end
        if (d == 3 && c == SCAN_DIV - 1) begin
          blank_lz = nb;
          dp_en    = nd;
        end
        exp_v = {e.e_an, e.e_seg, e.e_dp, (c == 0) ? e.e_fd : 1'b0};
        vectors++;
        if ({an, seg, dp, frame_done} !== exp_v) begin
          miscompares++;
          $display("FAIL %s digit %0d cycle %0d: {an,seg,dp,fd}=%b_%b_%b_%b, required %b_%b_%b_%b",
                   tag, d, c, an, seg, dp, frame_done, exp_v[12:9], exp_v[8:2], exp_v[1], exp_v[0]);
        end
        @(negedge clk);
      end
    end
    bcd_load = 1'b0;
    if (ls >= 0) begin
      if (ls == 3 && lc == SCAN_DIV - 1) begin
        m_disp = m_pend;
        m_pend = lv;
      end else begin
        m_pend = lv;
        m_disp = m_pend;
      end
    end else begin
      m_disp = m_pend;
    end
    cur_blz = nb;
    cur_dp  = nd;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    vectors++;
    if ({an, seg, dp, frame_done} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_hold: {an,seg,dp,fd}=%b_%b_%b_%b, required 1111_1111111_1_0", an, seg, dp, frame_done);
    end
    rst_n = 1'b1;
    check_idle("startup");
    run_frame(-1, 0, 16'h0000, 1'b0, 4'b0000, "startup_frame");
  endtask

  task automatic test_frame_atomic;
    run_frame(2, 1, 16'h1234, 1'b0, 4'b0000, "atomic_old");
    run_frame(-1, 0, 16'h0000, 1'b0, 4'b0000, "atomic_new");
  endtask

  task automatic test_load_collision;
    run_frame(3, SCAN_DIV - 1, 16'h5678, 1'b0, 4'b0000, "collide_load");
    run_frame(-1, 0, 16'h0000, 1'b0, 4'b0000, "collide_prior");
    run_frame(-1, 0, 16'h0000, 1'b0, 4'b0000, "collide_new");
  endtask

  task automatic test_blanking_dp;
    run_frame(1, 0, 16'h0045, 1'b1, 4'b0000, "lz_setup");
    run_frame(1, 0, 16'h0000, 1'b1, 4'b0000, "lz_0045");
    run_frame(1, 0, 16'h0045, 1'b0, 4'b0000, "lz_0000");
    run_frame(1, 0, 16'h00A1, 1'b1, 4'b0100, "nolz_0045");
    run_frame(-1, 0, 16'h0000, 1'b1, 4'b0100, "dash_dp");
  endtask

  task automatic test_async_reset;
    repeat (2 * SCAN_DIV) @(negedge clk);
    vectors++;
    if (an !== 4'b1011) begin
      miscompares++;
      $display("FAIL async_pre: an=%b, required 1011", an);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({an, seg, dp, frame_done} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL async_reset: {an,seg,dp,fd}=%b_%b_%b_%b, required 1111_1111111_1_0", an, seg, dp, frame_done);
    end
    blank_lz = 1'b0;
    dp_en    = 4'b0000;
    bcd_in   = 16'h0000;
    m_pend   = 16'h0000;
    m_disp   = 16'h0000;
    cur_blz  = 1'b0;
    cur_dp   = 4'b0000;
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    check_idle("restart");
    run_frame(-1, 0, 16'h0000, 1'b0, 4'b0000, "restart_frame");
  endtask

  initial begin
    test_reset();
    test_frame_atomic();
    test_load_collision();
    test_blanking_dp();
    test_async_reset();
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
